// File: rtl/vmem_port_arbiter_if.sv
// Bundle of the scalar LSU, vector LSU/VRF and datamem signals that meet at the port arbiter.
interface vmem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int VL_W       = 6
);
  logic                  s_req_i;
  logic                  s_we_i;
  logic [1:0]            s_size_i;
  logic                  s_unsigned_i;
  logic [DATA_WIDTH-1:0] s_addr_i;
  logic [DATA_WIDTH-1:0] s_wdata_i;
  logic                  s_gnt_o;
  logic [DATA_WIDTH-1:0] s_rdata_o;

  logic                  v_start_i;
  logic                  v_store_i;
  logic [1:0]            v_eew_i;
  logic [DATA_WIDTH-1:0] v_base_i;
  logic [DATA_WIDTH-1:0] v_stride_i;
  logic [VL_W-1:0]       v_vl_i;
  logic [DATA_WIDTH-1:0] v_wdata_i;
  logic [VL_W-1:0]       v_elem_idx_o;
  logic [DATA_WIDTH-1:0] v_rdata_o;
  logic [VL_W-1:0]       v_rdata_idx_o;
  logic                  v_rdata_valid_o;
  logic                  v_busy_o;
  logic                  v_done_o;
  logic                  v_err_o;

  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [1:0]            mem_size_o;
  logic                  mem_unsigned_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  // Arbiter side of the bundle.
  modport slave (
    input  s_req_i, s_we_i, s_size_i, s_unsigned_i, s_addr_i, s_wdata_i,
    output s_gnt_o, s_rdata_o,
    input  v_start_i, v_store_i, v_eew_i, v_base_i, v_stride_i, v_vl_i, v_wdata_i,
    output v_elem_idx_o, v_rdata_o, v_rdata_idx_o, v_rdata_valid_o, v_busy_o, v_done_o, v_err_o,
    output mem_read_o, mem_write_o, mem_size_o, mem_unsigned_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // Environment side: LSUs, VRF and datamem.
  modport master (
    output s_req_i, s_we_i, s_size_i, s_unsigned_i, s_addr_i, s_wdata_i,
    input  s_gnt_o, s_rdata_o,
    output v_start_i, v_store_i, v_eew_i, v_base_i, v_stride_i, v_vl_i, v_wdata_i,
    input  v_elem_idx_o, v_rdata_o, v_rdata_idx_o, v_rdata_valid_o, v_busy_o, v_done_o, v_err_o,
    input  mem_read_o, mem_write_o, mem_size_o, mem_unsigned_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/vmem_port_arbiter.sv
// Shares the single datamem port between the scalar LSU and a strided vector
// load/store sequencer. Scalar has priority; a stall counter forces a vector
// slot after STARVE_LIMIT consecutive lost cycles.
module vmem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int VL_W         = 6,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  vmem_port_arbiter_if.slave bus
);

  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state;
  logic                  store_q;
  logic [1:0]            eew_q;
  logic [DATA_WIDTH-1:0] stride_q;
  logic [VL_W-1:0]       vl_q;
  logic [DATA_WIDTH-1:0] ptr_q;
  logic [VL_W-1:0]       idx_q;
  logic [SC_W-1:0]       stall_cnt;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [VL_W-1:0]       rdata_idx_q;
  logic                  rdata_valid_q;

  logic v_win;
  logic misalign;
  logic v_issue;
  logic s_gnt;

  // A misaligned element still uses its slot; it just never reaches memory.
  assign v_win    = (state == RUN) && (!bus.s_req_i || (stall_cnt == SC_W'(STARVE_LIMIT)));
  assign misalign = ((eew_q == 2'b01) && ptr_q[0]) || (eew_q[1] && (ptr_q[1:0] != 2'b00));
  assign v_issue  = v_win && !misalign;
  assign s_gnt    = bus.s_req_i && !v_win;

  assign bus.s_gnt_o         = s_gnt;
  assign bus.s_rdata_o       = (s_gnt && !bus.s_we_i) ? bus.mem_rdata_i : '0;
  assign bus.v_elem_idx_o    = idx_q;
  assign bus.v_rdata_o       = rdata_q;
  assign bus.v_rdata_idx_o   = rdata_idx_q;
  assign bus.v_rdata_valid_o = rdata_valid_q;
  assign bus.v_busy_o        = (state != IDLE);
  assign bus.v_done_o        = (state == DONE);
  assign bus.v_err_o         = err_q;

  // Drive the datamem port from whichever side owns it; idle port stays all-zero.
  always_comb begin
    bus.mem_read_o     = 1'b0;
    bus.mem_write_o    = 1'b0;
    bus.mem_size_o     = 2'b00;
    bus.mem_unsigned_o = 1'b0;
    bus.mem_addr_o     = '0;
    bus.mem_wdata_o    = '0;
    if (v_issue) begin
      bus.mem_read_o     = !store_q;
      bus.mem_write_o    = store_q;
      bus.mem_size_o     = eew_q;
      bus.mem_unsigned_o = !store_q;
      bus.mem_addr_o     = ptr_q;
      bus.mem_wdata_o    = store_q ? bus.v_wdata_i : '0;
    end else if (s_gnt) begin
      bus.mem_read_o     = !bus.s_we_i;
      bus.mem_write_o    = bus.s_we_i;
      bus.mem_size_o     = bus.s_size_i;
      bus.mem_unsigned_o = bus.s_unsigned_i;
      bus.mem_addr_o     = bus.s_addr_i;
      bus.mem_wdata_o    = bus.s_wdata_i;
    end
  end

  // Sequencer FSM: latch the op in IDLE, walk the elements in RUN, pulse done in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      store_q  <= 1'b0;
      eew_q    <= 2'b00;
      stride_q <= '0;
      vl_q     <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.v_start_i) begin
            store_q  <= bus.v_store_i;
            eew_q    <= bus.v_eew_i;
            stride_q <= bus.v_stride_i;
            vl_q     <= bus.v_vl_i;
            ptr_q    <= bus.v_base_i;
            idx_q    <= '0;
            err_q    <= 1'b0;
            state    <= (bus.v_vl_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (v_win) begin
            ptr_q <= ptr_q + stride_q;
            idx_q <= idx_q + VL_W'(1);
            if (misalign) err_q <= 1'b1;
            if (idx_q == vl_q - VL_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Count consecutive RUN cycles the vector side lost to the scalar LSU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && !v_win) begin
      stall_cnt <= stall_cnt + SC_W'(1);
    end else begin
      stall_cnt <= '0;
    end
  end

  // Capture vector load data at the edge that ends its issue cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q       <= '0;
      rdata_idx_q   <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= v_issue && !store_q;
      if (v_issue && !store_q) begin
        rdata_q     <= bus.mem_rdata_i;
        rdata_idx_q <= idx_q;
      end
    end
  end

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Directed bench for vmem_port_arbiter with a small byte-addressed datamem model.
module tb_vmem_port_arbiter;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;

  logic [7:0] mem [0:4095];

  vmem_port_arbiter_if #(.DATA_WIDTH(32), .VL_W(6)) bus ();

  vmem_port_arbiter #(.DATA_WIDTH(32), .VL_W(6), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] readModel(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [11:0] i;
    logic [31:0] w;
    i = a[11:0];
    w = {mem[i + 12'd3], mem[i + 12'd2], mem[i + 12'd1], mem[i]};
    case (sz)
      2'b00:   readModel = u ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'b01:   readModel = u ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: readModel = w;
    endcase
  endfunction

  // Combinational datamem read.
  always_comb begin
    bus.mem_rdata_i = '0;
    if (bus.mem_read_o) bus.mem_rdata_i = readModel(bus.mem_addr_o, bus.mem_size_o, bus.mem_unsigned_o);
  end

  // Datamem write commits on the rising edge.
  always @(posedge clk) begin
    if (bus.mem_write_o) begin
      mem[bus.mem_addr_o[11:0]] <= bus.mem_wdata_o[7:0];
      if (bus.mem_size_o != 2'b00) mem[bus.mem_addr_o[11:0] + 12'd1] <= bus.mem_wdata_o[15:8];
      if (bus.mem_size_o[1]) begin
        mem[bus.mem_addr_o[11:0] + 12'd2] <= bus.mem_wdata_o[23:16];
        mem[bus.mem_addr_o[11:0] + 12'd3] <= bus.mem_wdata_o[31:24];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wdata);
    bus.s_req_i      = req;
    bus.s_we_i       = we;
    bus.s_size_i     = sz;
    bus.s_unsigned_i = 1'b0;
    bus.s_addr_i     = addr;
    bus.s_wdata_i    = wdata;
  endtask

  task automatic startVector(input logic store, input logic [1:0] eew, input logic [31:0] base, input logic [31:0] stride, input logic [5:0] vl);
    bus.v_start_i  = 1'b1;
    bus.v_store_i  = store;
    bus.v_eew_i    = eew;
    bus.v_base_i   = base;
    bus.v_stride_i = stride;
    bus.v_vl_i     = vl;
  endtask

  task automatic preloadWord(input logic [11:0] a, input logic [31:0] d);
    {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]} = d;
  endtask

  function automatic logic [31:0] peekWord(input logic [11:0] a);
    peekWord = {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
  endfunction

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    bus.v_start_i  = 1'b0;
    bus.v_store_i  = 1'b0;
    bus.v_eew_i    = 2'b00;
    bus.v_base_i   = '0;
    bus.v_stride_i = '0;
    bus.v_vl_i     = '0;
    bus.v_wdata_i  = '0;
    rst = 1'b0;
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk); #1;
    checkOutput("rst_busy", {31'd0, bus.v_busy_o}, 32'd0);
    checkOutput("rst_err", {31'd0, bus.v_err_o}, 32'd0);
    checkOutput("rst_mem_rd_wr", {30'd0, bus.mem_read_o, bus.mem_write_o}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, bus.v_rdata_valid_o}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Scalar store then load at 0x40
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h40, 32'hCAFEBABE); #1;
    checkOutput("sw_gnt", {31'd0, bus.s_gnt_o}, 32'd1);
    checkOutput("sw_write", {31'd0, bus.mem_write_o}, 32'd1);
    checkOutput("sw_addr", bus.mem_addr_o, 32'h40);
    checkOutput("sw_wdata", bus.mem_wdata_o, 32'hCAFEBABE);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 2'b10, 32'h40, 32'h0); #1;
    checkOutput("lw_gnt", {31'd0, bus.s_gnt_o}, 32'd1);
    checkOutput("lw_read", {31'd0, bus.mem_read_o}, 32'd1);
    checkOutput("lw_rdata", bus.s_rdata_o, 32'hCAFEBABE);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0); #1;
    checkOutput("idle_gnt", {31'd0, bus.s_gnt_o}, 32'd0);
    checkOutput("idle_addr", bus.mem_addr_o, 32'h0);

    // Vector word load vl=4 base 0x100 stride 4
    for (int i = 0; i < 4; i++) preloadWord(12'h100 + 12'(4 * i), 32'hD000_0000 + 32'(i));
    @(negedge clk);
    startVector(1'b0, 2'b10, 32'h100, 32'd4, 6'd4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.v_start_i = 1'b0; #1;
      checkOutput("vl_read", {31'd0, bus.mem_read_o}, 32'd1);
      checkOutput("vl_addr", bus.mem_addr_o, 32'h100 + 32'(4 * c));
      checkOutput("vl_unsigned", {31'd0, bus.mem_unsigned_o}, 32'd1);
      checkOutput("vl_elem_idx", {26'd0, bus.v_elem_idx_o}, 32'(c));
      checkOutput("vl_rvalid", {31'd0, bus.v_rdata_valid_o}, (c == 0) ? 32'd0 : 32'd1);
      if (c > 0) begin
        checkOutput("vl_ridx", {26'd0, bus.v_rdata_idx_o}, 32'(c - 1));
        checkOutput("vl_rdata", bus.v_rdata_o, 32'hD000_0000 + 32'(c - 1));
      end
    end
    @(negedge clk); #1;
    checkOutput("vl_done", {31'd0, bus.v_done_o}, 32'd1);
    checkOutput("vl_last_valid", {31'd0, bus.v_rdata_valid_o}, 32'd1);
    checkOutput("vl_last_idx", {26'd0, bus.v_rdata_idx_o}, 32'd3);
    checkOutput("vl_last_data", bus.v_rdata_o, 32'hD000_0003);
    checkOutput("vl_done_noread", {31'd0, bus.mem_read_o}, 32'd0);
    @(negedge clk); #1;
    checkOutput("vl_idle_busy", {31'd0, bus.v_busy_o}, 32'd0);
    checkOutput("vl_idle_done", {31'd0, bus.v_done_o}, 32'd0);

    // Half load base 0x200 stride 3 vl=3: element 1 at 0x203 is misaligned
    preloadWord(12'h200, 32'h0000_8765);
    preloadWord(12'h204, 32'hF00D_0000);
    @(negedge clk);
    startVector(1'b0, 2'b01, 32'h200, 32'd3, 6'd3);
    @(negedge clk);
    bus.v_start_i = 1'b0; #1;
    checkOutput("mis_read0", {31'd0, bus.mem_read_o}, 32'd1);
    checkOutput("mis_addr0", bus.mem_addr_o, 32'h200);
    checkOutput("mis_size0", {30'd0, bus.mem_size_o}, 32'd1);
    @(negedge clk); #1;
    checkOutput("mis_strobe1", {30'd0, bus.mem_read_o, bus.mem_write_o}, 32'd0);
    checkOutput("mis_ridx0", {26'd0, bus.v_rdata_idx_o}, 32'd0);
    checkOutput("mis_rdata0", bus.v_rdata_o, 32'h0000_8765);
    checkOutput("mis_err_early", {31'd0, bus.v_err_o}, 32'd0);
    @(negedge clk); #1;
    checkOutput("mis_read2", {31'd0, bus.mem_read_o}, 32'd1);
    checkOutput("mis_addr2", bus.mem_addr_o, 32'h206);
    checkOutput("mis_no_valid1", {31'd0, bus.v_rdata_valid_o}, 32'd0);
    checkOutput("mis_err", {31'd0, bus.v_err_o}, 32'd1);
    @(negedge clk); #1;
    checkOutput("mis_done", {31'd0, bus.v_done_o}, 32'd1);
    checkOutput("mis_ridx2", {26'd0, bus.v_rdata_idx_o}, 32'd2);
    checkOutput("mis_rdata2", bus.v_rdata_o, 32'h0000_F00D);
    @(negedge clk); #1;
    checkOutput("mis_err_sticky", {31'd0, bus.v_err_o}, 32'd1);

    // vl=0: one busy/done cycle, no strobes, error flag cleared by the start
    @(negedge clk);
    startVector(1'b0, 2'b10, 32'h100, 32'd4, 6'd0);
    @(negedge clk);
    bus.v_start_i = 1'b0; #1;
    checkOutput("vl0_busy", {31'd0, bus.v_busy_o}, 32'd1);
    checkOutput("vl0_done", {31'd0, bus.v_done_o}, 32'd1);
    checkOutput("vl0_strobe", {30'd0, bus.mem_read_o, bus.mem_write_o}, 32'd0);
    checkOutput("vl0_err_clr", {31'd0, bus.v_err_o}, 32'd0);
    @(negedge clk); #1;
    checkOutput("vl0_idle_busy", {31'd0, bus.v_busy_o}, 32'd0);
    checkOutput("vl0_idle_done", {31'd0, bus.v_done_o}, 32'd0);

    // Starvation guard: scalar load held high during a vector store vl=8
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
    startVector(1'b1, 2'b10, 32'h300, 32'd4, 6'd8);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.v_start_i = 1'b0;
      bus.v_wdata_i = 32'hA000_0000 | {26'd0, bus.v_elem_idx_o}; #1;
      checkOutput("stv_gnt", {31'd0, bus.s_gnt_o}, (c % 5 == 0) ? 32'd0 : 32'd1);
      checkOutput("stv_write", {31'd0, bus.mem_write_o}, (c % 5 == 0) ? 32'd1 : 32'd0);
      checkOutput("stv_srdata", bus.s_rdata_o, (c % 5 == 0) ? 32'd0 : 32'hCAFEBABE);
      if (c % 5 == 0) checkOutput("stv_addr", bus.mem_addr_o, 32'h300 + 32'(4 * (c / 5 - 1)));
    end
    @(negedge clk); #1;
    checkOutput("stv_done", {31'd0, bus.v_done_o}, 32'd1);
    checkOutput("stv_done_gnt", {31'd0, bus.s_gnt_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) checkOutput("stv_mem", peekWord(12'h300 + 12'(4 * i)), 32'hA000_0000 + 32'(i));

    // Reset after two of eight store elements
    @(negedge clk);
    startVector(1'b1, 2'b10, 32'h400, 32'd4, 6'd8);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.v_start_i = 1'b0;
      bus.v_wdata_i = 32'h5500_0000 | {26'd0, bus.v_elem_idx_o}; #1;
      checkOutput("rstop_write", {31'd0, bus.mem_write_o}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b1; #1;
    checkOutput("rstop_busy", {31'd0, bus.v_busy_o}, 32'd0);
    checkOutput("rstop_strobe", {30'd0, bus.mem_read_o, bus.mem_write_o}, 32'd0);
    checkOutput("rstop_idx", {26'd0, bus.v_elem_idx_o}, 32'd0);
    checkOutput("rstop_addr", bus.mem_addr_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      checkOutput("rstop_post", {29'd0, bus.mem_read_o, bus.mem_write_o, bus.v_done_o}, 32'd0);
    end
    checkOutput("rstop_mem1", peekWord(12'h404), 32'h5500_0001);
    checkOutput("rstop_mem2", peekWord(12'h408), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
